// File: rtl/memory_controller_pkg.sv
// Shared definitions for the memory controller: condition codes from core_control,
// FSM state encoding and the fixed width of the length field.
package memory_controller_pkg;

  localparam logic [2:0] COND_NONE  = 3'b000;
  localparam logic [2:0] COND_STORE = 3'b100;
  localparam logic [2:0] COND_TRANS = 3'b010;
  localparam logic [2:0] COND_PROC  = 3'b001;

  localparam int LEN_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STORE = 3'd1,
    ST_XFER  = 3'd2,
    ST_ACK   = 3'd3,
    ST_WAIT  = 3'd4
  } mc_state_e;

endpackage

// File: rtl/memory_controller_if.sv
// Bus between core_control / data input port / processing unit (master)
// and the memory controller (slave).
interface memory_controller_if
  import memory_controller_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CHUNK  = 4
);
  logic [2:0]              mc_data_contition;
  logic [LEN_W-1:0]        mc_data_length;
  logic [DATA_W-1:0]       mc_data_in;
  logic                    mc_data_in_valid;
  logic                    mc_data_in_ready;
  logic                    mc_done;
  logic                    mc_data_done;
  logic [CHUNK*DATA_W-1:0] mc_reg_data;
  logic [2:0]              mc_reg_count;

  modport master (
    output mc_data_contition, mc_data_length, mc_data_in, mc_data_in_valid,
    input  mc_data_in_ready, mc_done, mc_data_done, mc_reg_data, mc_reg_count
  );

  modport slave (
    input  mc_data_contition, mc_data_length, mc_data_in, mc_data_in_valid,
    output mc_data_in_ready, mc_done, mc_data_done, mc_reg_data, mc_reg_count
  );
endinterface

// File: rtl/memory_controller_storage.sv
// Flop-array word store: one synchronous write port, one asynchronous read port.
// Contents are plain data and are deliberately not reset.
module memory_controller_storage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/memory_controller.sv
// Responder to core_control: stores an L-word stream on 100, hands it out in
// CHUNK-word slices to the register bank on 010, and reports via done pulses.
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int CHUNK  = 4
) (
  input  logic mc_clk,
  input  logic mc_reset,
  memory_controller_if.slave bus
);

  mc_state_e               r_state, w_next;
  logic [ADDR_W-1:0]       r_len, r_wr_ptr, r_rd_ptr, r_xfer_n, r_xfer_i;
  logic [2:0]              r_cur, r_served;
  logic                    r_empty_req, r_done, r_data_done;
  logic [CHUNK*DATA_W-1:0] r_bank, w_bank_next;
  logic [2:0]              r_count;
  logic [2:0]              w_cond;
  logic                    w_abort, w_start_store, w_start_xfer, w_ack_proc;
  logic                    w_store_fire, w_we;
  logic [ADDR_W-1:0]       w_n;
  logic [DATA_W-1:0]       w_rd_data;

  function automatic logic [ADDR_W-1:0] xfer_len(input logic [ADDR_W-1:0] remaining);
    return (remaining < ADDR_W'(CHUNK)) ? remaining : ADDR_W'(CHUNK);
  endfunction

  assign w_cond       = bus.mc_data_contition;
  assign w_abort      = (w_cond == COND_NONE);
  assign w_n          = xfer_len(r_len - r_rd_ptr);
  assign w_store_fire = (r_state == ST_STORE) && bus.mc_data_in_valid;
  assign w_we         = w_store_fire && !w_abort;

  memory_controller_storage #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_storage (
    .i_clk   (mc_clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.mc_data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge mc_clk or posedge mc_reset) begin
    if (mc_reset) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // WAIT only reacts to a code that differs from the one last served, so a
  // request held steady is answered exactly once.
  always_comb begin
    w_next        = r_state;
    w_start_store = 1'b0;
    w_start_xfer  = 1'b0;
    w_ack_proc    = 1'b0;
    if (w_abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_WAIT: begin
          if (r_state == ST_IDLE || w_cond != r_served) begin
            if (w_cond == COND_STORE) begin
              w_start_store = 1'b1;
              w_next = (bus.mc_data_length == '0) ? ST_ACK : ST_STORE;
            end else if (w_cond == COND_TRANS) begin
              w_start_xfer = 1'b1;
              w_next = (w_n == '0) ? ST_ACK : ST_XFER;
            end else if (w_cond == COND_PROC) begin
              w_ack_proc = 1'b1;
              w_next = ST_WAIT;
            end
          end
        end
        ST_STORE: if (bus.mc_data_in_valid && r_wr_ptr == r_len - ADDR_W'(1)) w_next = ST_ACK;
        ST_XFER:  if (r_xfer_i + ADDR_W'(1) == r_xfer_n) w_next = ST_ACK;
        ST_ACK:   w_next = ST_WAIT;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // First word of a chunk clears stale slots so short tails read as zero.
  always_comb begin
    w_bank_next = (r_xfer_i == '0) ? '0 : r_bank;
    for (int k = 0; k < CHUNK; k++) begin
      if (r_xfer_i == ADDR_W'(k)) w_bank_next[k*DATA_W +: DATA_W] = w_rd_data;
    end
  end

  always_ff @(posedge mc_clk or posedge mc_reset) begin
    if (mc_reset) begin
      r_len       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_xfer_n    <= '0;
      r_xfer_i    <= '0;
      r_cur       <= COND_NONE;
      r_served    <= COND_NONE;
      r_empty_req <= 1'b0;
      r_done      <= 1'b0;
      r_data_done <= 1'b0;
      r_bank      <= '0;
      r_count     <= '0;
    end else begin
      r_done <= (r_state == ST_ACK) && !w_abort;
      if (w_abort) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_served    <= COND_NONE;
        r_empty_req <= 1'b0;
        r_data_done <= 1'b0;
      end else begin
        if (w_start_store) begin
          r_len       <= ADDR_W'(bus.mc_data_length);
          r_wr_ptr    <= '0;
          r_rd_ptr    <= '0;
          r_cur       <= w_cond;
          r_empty_req <= 1'b0;
        end
        if (w_start_xfer) begin
          r_xfer_n    <= w_n;
          r_xfer_i    <= '0;
          r_cur       <= w_cond;
          r_empty_req <= (w_n == '0);
        end
        if (w_ack_proc)   r_served <= w_cond;
        if (w_store_fire) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        if (r_state == ST_XFER) begin
          r_bank   <= w_bank_next;
          r_count  <= 3'(r_xfer_i + ADDR_W'(1));
          r_xfer_i <= r_xfer_i + ADDR_W'(1);
          r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
        end
        if (r_state == ST_ACK) begin
          r_served <= r_cur;
          if (r_empty_req) r_data_done <= 1'b1;
        end
      end
    end
  end

  assign bus.mc_data_in_ready = (r_state == ST_STORE);
  assign bus.mc_done          = r_done;
  assign bus.mc_data_done     = r_data_done;
  assign bus.mc_reg_data      = r_bank;
  assign bus.mc_reg_count     = r_count;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: store, chunked transfer, hold, abort and reset scenarios.
module tb_memory_controller;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  memory_controller_if #(.DATA_W(8), .CHUNK(4)) bus ();

  memory_controller #(
    .DATA_W (8),
    .ADDR_W (6),
    .CHUNK  (4)
  ) dut (
    .mc_clk   (clk),
    .mc_reset (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] c, input logic [5:0] len);
    bus.mc_data_contition = c;
    bus.mc_data_length    = len;
    tick();
  endtask

  task automatic send_words(input logic [7:0] base, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      bus.mc_data_in       = base + 8'(i);
      bus.mc_data_in_valid = 1'b1;
      tick();
      bus.mc_data_in_valid = 1'b0;
      if (gaps && i < n - 1 && (i % 2 == 0)) tick();
    end
  endtask

  task automatic run_until_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.mc_done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1;
    bus.mc_data_contition = 3'b000;
    bus.mc_data_length    = '0;
    bus.mc_data_in        = '0;
    bus.mc_data_in_valid  = 1'b0;
    tick(); tick();
    checks++; if (bus.mc_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", bus.mc_done); end
    checks++; if (bus.mc_data_done !== 1'b0) begin errors++; $display("FAIL rst_data_done got=%b exp=0", bus.mc_data_done); end
    checks++; if (bus.mc_data_in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", bus.mc_data_in_ready); end
    checks++; if (bus.mc_reg_data !== 32'h0) begin errors++; $display("FAIL rst_reg_data got=%h exp=0", bus.mc_reg_data); end
    checks++; if (bus.mc_reg_count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", bus.mc_reg_count); end
    rst = 1'b0;
    tick();
    issue(3'b100, 6'd6);
    send_words(8'h81, 3, 1'b0);
    rst = 1'b1;
    #1;
    checks++; if (bus.mc_data_in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b exp=0", bus.mc_data_in_ready); end
    checks++; if (bus.mc_done !== 1'b0 || bus.mc_data_done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b%b exp=00", bus.mc_done, bus.mc_data_done); end
    bus.mc_data_contition = 3'b000;
    tick(); tick();
    rst = 1'b0;
    tick();
    issue(3'b100, 6'd2);
    checks++; if (bus.mc_data_in_ready !== 1'b1) begin errors++; $display("FAIL restore_ready got=%b exp=1", bus.mc_data_in_ready); end
    send_words(8'hA1, 2, 1'b0);
    tick();
    checks++; if (bus.mc_done !== 1'b1) begin errors++; $display("FAIL restore_done got=%b exp=1", bus.mc_done); end
    issue(3'b001, 6'd0);
    issue(3'b010, 6'd0);
    run_until_done(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL restore_xfer_lat got=%0d exp=3", lat); end
    checks++; if (bus.mc_reg_data !== 32'h0000A2A1) begin errors++; $display("FAIL restore_bank got=%h exp=0000a2a1", bus.mc_reg_data); end
    issue(3'b000, 6'd0);
  endtask

  task automatic test_store_xfer();
    int lat;
    issue(3'b100, 6'd6);
    checks++; if (bus.mc_data_in_ready !== 1'b1) begin errors++; $display("FAIL store_ready got=%b exp=1", bus.mc_data_in_ready); end
    send_words(8'h11, 6, 1'b1);
    checks++; if (bus.mc_data_in_ready !== 1'b0) begin errors++; $display("FAIL store_ready_drop got=%b exp=0", bus.mc_data_in_ready); end
    checks++; if (bus.mc_done !== 1'b0) begin errors++; $display("FAIL store_done_early got=%b exp=0", bus.mc_done); end
    tick();
    checks++; if (bus.mc_done !== 1'b1) begin errors++; $display("FAIL store_done got=%b exp=1", bus.mc_done); end
    tick();
    checks++; if (bus.mc_done !== 1'b0) begin errors++; $display("FAIL store_done_width got=%b exp=0", bus.mc_done); end
    issue(3'b010, 6'd0);
    run_until_done(lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL xfer1_lat got=%0d exp=5", lat); end
    checks++; if (bus.mc_reg_data !== 32'h14131211) begin errors++; $display("FAIL xfer1_bank got=%h exp=14131211", bus.mc_reg_data); end
    checks++; if (bus.mc_reg_count !== 3'd4) begin errors++; $display("FAIL xfer1_count got=%0d exp=4", bus.mc_reg_count); end
    issue(3'b001, 6'd0);
    issue(3'b010, 6'd0);
    run_until_done(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL xfer2_lat got=%0d exp=3", lat); end
    checks++; if (bus.mc_reg_data !== 32'h00001615) begin errors++; $display("FAIL xfer2_bank got=%h exp=00001615", bus.mc_reg_data); end
    checks++; if (bus.mc_reg_count !== 3'd2) begin errors++; $display("FAIL xfer2_count got=%0d exp=2", bus.mc_reg_count); end
    checks++; if (bus.mc_data_done !== 1'b0) begin errors++; $display("FAIL xfer2_data_done got=%b exp=0", bus.mc_data_done); end
    issue(3'b001, 6'd0);
    issue(3'b010, 6'd0);
    run_until_done(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL xfer3_lat got=%0d exp=1", lat); end
    checks++; if (bus.mc_data_done !== 1'b1) begin errors++; $display("FAIL xfer3_data_done got=%b exp=1", bus.mc_data_done); end
    issue(3'b001, 6'd0);
    checks++; if (bus.mc_data_done !== 1'b1) begin errors++; $display("FAIL proc_keeps_data_done got=%b exp=1", bus.mc_data_done); end
    issue(3'b000, 6'd0);
    checks++; if (bus.mc_data_done !== 1'b0) begin errors++; $display("FAIL none_clears_data_done got=%b exp=0", bus.mc_data_done); end
  endtask

  task automatic test_zero_length();
    int lat;
    issue(3'b100, 6'd0);
    checks++; if (bus.mc_data_in_ready !== 1'b0) begin errors++; $display("FAIL l0_ready got=%b exp=0", bus.mc_data_in_ready); end
    run_until_done(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL l0_store_lat got=%0d exp=1", lat); end
    checks++; if (bus.mc_data_done !== 1'b0) begin errors++; $display("FAIL l0_store_data_done got=%b exp=0", bus.mc_data_done); end
    issue(3'b001, 6'd0);
    issue(3'b010, 6'd0);
    run_until_done(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL l0_xfer_lat got=%0d exp=1", lat); end
    checks++; if (bus.mc_data_done !== 1'b1) begin errors++; $display("FAIL l0_xfer_data_done got=%b exp=1", bus.mc_data_done); end
    checks++; if (bus.mc_reg_data !== 32'h00001615 || bus.mc_reg_count !== 3'd2) begin
      errors++; $display("FAIL l0_bank_kept got=%h/%0d exp=00001615/2", bus.mc_reg_data, bus.mc_reg_count);
    end
    issue(3'b000, 6'd0);
  endtask

  task automatic test_hold();
    int dcnt, rcnt;
    issue(3'b100, 6'd3);
    send_words(8'h31, 3, 1'b0);
    dcnt = 0; rcnt = 0;
    for (int k = 0; k < 22; k++) begin
      tick();
      if (bus.mc_done === 1'b1) dcnt++;
      if (bus.mc_data_in_ready === 1'b1) rcnt++;
    end
    checks++; if (dcnt !== 1) begin errors++; $display("FAIL hold_store_pulses got=%0d exp=1", dcnt); end
    checks++; if (rcnt !== 0) begin errors++; $display("FAIL hold_store_ready got=%0d exp=0", rcnt); end
    bus.mc_data_contition = 3'b010;
    dcnt = 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (bus.mc_done === 1'b1) dcnt++;
    end
    checks++; if (dcnt !== 1) begin errors++; $display("FAIL hold_xfer_pulses got=%0d exp=1", dcnt); end
    checks++; if (bus.mc_reg_data !== 32'h00333231 || bus.mc_reg_count !== 3'd3) begin
      errors++; $display("FAIL hold_bank got=%h/%0d exp=00333231/3", bus.mc_reg_data, bus.mc_reg_count);
    end
    issue(3'b000, 6'd0);
  endtask

  task automatic test_abort_xfer();
    int dcnt, lat;
    issue(3'b100, 6'd5);
    send_words(8'h51, 5, 1'b0);
    tick();
    issue(3'b001, 6'd0);
    issue(3'b010, 6'd0);
    tick(); tick();
    bus.mc_data_contition = 3'b000;
    dcnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.mc_done === 1'b1) dcnt++;
    end
    checks++; if (dcnt !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", dcnt); end
    checks++; if (bus.mc_reg_data !== 32'h00005251 || bus.mc_reg_count !== 3'd2) begin
      errors++; $display("FAIL abort_bank_kept got=%h/%0d exp=00005251/2", bus.mc_reg_data, bus.mc_reg_count);
    end
    issue(3'b100, 6'd2);
    send_words(8'h61, 2, 1'b0);
    tick();
    checks++; if (bus.mc_done !== 1'b1) begin errors++; $display("FAIL abort_restore_done got=%b exp=1", bus.mc_done); end
    issue(3'b001, 6'd0);
    issue(3'b010, 6'd0);
    run_until_done(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL abort_xfer_lat got=%0d exp=3", lat); end
    checks++; if (bus.mc_reg_data !== 32'h00006261) begin errors++; $display("FAIL abort_wrptr_restart got=%h exp=00006261", bus.mc_reg_data); end
    issue(3'b000, 6'd0);
  endtask

  task automatic test_chunked_run();
    int lat, dcnt;
    logic [31:0] exp_bank [3];
    int          exp_lat  [3];
    logic [2:0]  exp_cnt  [3];
    exp_bank[0] = 32'h04030201; exp_lat[0] = 5; exp_cnt[0] = 3'd4;
    exp_bank[1] = 32'h08070605; exp_lat[1] = 5; exp_cnt[1] = 3'd4;
    exp_bank[2] = 32'h00000009; exp_lat[2] = 2; exp_cnt[2] = 3'd1;
    issue(3'b100, 6'd9);
    send_words(8'h01, 9, 1'b1);
    tick();
    checks++; if (bus.mc_done !== 1'b1) begin errors++; $display("FAIL run_store_done got=%b exp=1", bus.mc_done); end
    for (int t = 0; t < 3; t++) begin
      if (t == 1) begin
        bus.mc_data_contition = 3'b111;
        dcnt = 0;
        for (int k = 0; k < 3; k++) begin
          tick();
          if (bus.mc_done === 1'b1) dcnt++;
        end
        checks++; if (dcnt !== 0) begin errors++; $display("FAIL run_illegal_ignored got=%0d exp=0", dcnt); end
      end
      issue(3'b001, 6'd0);
      issue(3'b010, 6'd0);
      run_until_done(lat);
      checks++; if (lat !== exp_lat[t]) begin errors++; $display("FAIL run_xfer%0d_lat got=%0d exp=%0d", t, lat, exp_lat[t]); end
      checks++; if (bus.mc_reg_data !== exp_bank[t]) begin errors++; $display("FAIL run_xfer%0d_bank got=%h exp=%h", t, bus.mc_reg_data, exp_bank[t]); end
      checks++; if (bus.mc_reg_count !== exp_cnt[t]) begin errors++; $display("FAIL run_xfer%0d_count got=%0d exp=%0d", t, bus.mc_reg_count, exp_cnt[t]); end
      checks++; if (bus.mc_data_done !== 1'b0) begin errors++; $display("FAIL run_xfer%0d_data_done got=%b exp=0", t, bus.mc_data_done); end
    end
    issue(3'b001, 6'd0);
    issue(3'b010, 6'd0);
    run_until_done(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL run_final_lat got=%0d exp=1", lat); end
    checks++; if (bus.mc_data_done !== 1'b1) begin errors++; $display("FAIL run_final_data_done got=%b exp=1", bus.mc_data_done); end
    issue(3'b000, 6'd0);
    issue(3'b111, 6'd0);
    tick();
    checks++; if (bus.mc_done !== 1'b0 || bus.mc_data_in_ready !== 1'b0 || bus.mc_data_done !== 1'b0) begin
      errors++; $display("FAIL idle_illegal got=%b%b%b exp=000", bus.mc_done, bus.mc_data_in_ready, bus.mc_data_done);
    end
  endtask

  initial begin
    test_reset();
    test_store_xfer();
    test_zero_length();
    test_hold();
    test_abort_xfer();
    test_chunked_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
